// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter states, frame constants and parity helpers.
// The receiver imports the same package so both directions agree on parity and clamping.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_e;

   localparam logic       PAR_EVEN     = 1'b0;
   localparam logic       PAR_ODD      = 1'b1;
   localparam logic [5:0] PRESCALE_MIN = 6'd4;
   localparam int         DATA_W       = 8;

   function automatic logic calc_parity(input logic [DATA_W-1:0] data, input logic par_typ);
      logic p;
      case (par_typ)
         PAR_EVEN: p = ^data;
         PAR_ODD:  p = ~(^data);
         default:  p = ^data;
      endcase
      return p;
   endfunction

   // Prescale below the minimum would leave too few cycles per bit for the receiver.
   function automatic logic [5:0] clamp_prescale(input logic [5:0] prescale);
      return (prescale < PRESCALE_MIN) ? PRESCALE_MIN : prescale;
   endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Per-bit cycle counter and data-bit index for the UART transmitter.
module uart_tx_bit_timer
   import uart_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       in_data,
   input  logic [5:0] prescale,
   output logic       bit_done,
   output logic       last_data_bit
);

   logic [5:0] edge_cnt_q, edge_cnt_d;
   logic [2:0] bit_cnt_q,  bit_cnt_d;

   // Boundary decode and next-count computation.
   always_comb begin
      bit_done      = en && (edge_cnt_q == (prescale - 6'd1));
      last_data_bit = in_data && bit_done && (bit_cnt_q == 3'd7);

      if (!en) begin
         edge_cnt_d = 6'd0;
      end else if (bit_done) begin
         edge_cnt_d = 6'd0;
      end else begin
         edge_cnt_d = edge_cnt_q + 6'd1;
      end

      if (!en) begin
         bit_cnt_d = 3'd0;
      end else if (in_data && bit_done) begin
         bit_cnt_d = bit_cnt_q + 3'd1;
      end else begin
         bit_cnt_d = bit_cnt_q;
      end
   end

   // Counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         edge_cnt_q <= 6'd0;
         bit_cnt_q  <= 3'd0;
      end else begin
         edge_cnt_q <= edge_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start, 8 data bits LSB-first, optional parity, stop; Prescale cycles per bit.
module uart_tx_frame
   import uart_pkg::*;
(
   input  logic       CLK,
   input  logic       RST,
   input  logic [7:0] P_DATA,
   input  logic       Data_Valid,
   input  logic       PAR_EN,
   input  logic       PAR_TYP,
   input  logic [5:0] Prescale,
   output logic       TX_OUT,
   output logic       Busy
);

   tx_state_e  state_q,    state_d;
   logic [7:0] shift_q,    shift_d;
   logic       par_en_q,   par_en_d;
   logic       par_q,      par_d;
   logic [5:0] prescale_q, prescale_d;
   logic       tx_out_q,   tx_out_d;
   logic       busy_q,     busy_d;
   logic       bit_done;
   logic       last_data_bit;

   uart_tx_bit_timer u_timer (
      .clk           (CLK),
      .rst           (RST),
      .en            (busy_q),
      .in_data       (state_q == DATA),
      .prescale      (prescale_q),
      .bit_done      (bit_done),
      .last_data_bit (last_data_bit)
   );

   // Next-state logic; line and busy values are computed for the state being entered.
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      par_en_d   = par_en_q;
      par_d      = par_q;
      prescale_d = prescale_q;
      tx_out_d   = tx_out_q;
      busy_d     = busy_q;
      case (state_q)
         IDLE: begin
            tx_out_d = 1'b1;
            busy_d   = 1'b0;
            if (Data_Valid) begin
               shift_d    = P_DATA;
               par_en_d   = PAR_EN;
               par_d      = calc_parity(P_DATA, PAR_TYP);
               prescale_d = clamp_prescale(Prescale);
               state_d    = START;
               tx_out_d   = 1'b0;
               busy_d     = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         START: begin
            if (bit_done) begin
               state_d  = DATA;
               tx_out_d = shift_q[0];
            end else begin
               state_d = START;
            end
         end
         DATA: begin
            if (bit_done) begin
               shift_d = {1'b0, shift_q[7:1]};
               if (last_data_bit) begin
                  state_d  = par_en_q ? PARITY : STOP;
                  tx_out_d = par_en_q ? par_q : 1'b1;
               end else begin
                  tx_out_d = shift_q[1];
               end
            end else begin
               state_d = DATA;
            end
         end
         PARITY: begin
            if (bit_done) begin
               state_d  = STOP;
               tx_out_d = 1'b1;
            end else begin
               state_d = PARITY;
            end
         end
         STOP: begin
            if (bit_done) begin
               state_d  = IDLE;
               tx_out_d = 1'b1;
               busy_d   = 1'b0;
            end else begin
               state_d = STOP;
            end
         end
         default: begin
            state_d  = IDLE;
            tx_out_d = 1'b1;
            busy_d   = 1'b0;
         end
      endcase
   end

   // State, datapath and output registers; reset abandons any frame in flight.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= IDLE;
         shift_q    <= 8'd0;
         par_en_q   <= 1'b0;
         par_q      <= 1'b0;
         prescale_q <= PRESCALE_MIN;
         tx_out_q   <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         par_en_q   <= par_en_d;
         par_q      <= par_d;
         prescale_q <= prescale_d;
         tx_out_q   <= tx_out_d;
         busy_q     <= busy_d;
      end
   end

   assign TX_OUT = tx_out_q;
   assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame with a bench-side receiver for loopback.
module tb_uart_tx_frame;

   logic       CLK = 1'b0;
   logic       RST;
   logic [7:0] P_DATA;
   logic       Data_Valid;
   logic       PAR_EN;
   logic       PAR_TYP;
   logic [5:0] Prescale;
   logic       TX_OUT;
   logic       Busy;

   int n_vec = 0;
   int n_err = 0;

   uart_tx_frame dut (
      .CLK        (CLK),
      .RST        (RST),
      .P_DATA     (P_DATA),
      .Data_Valid (Data_Valid),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .Prescale   (Prescale),
      .TX_OUT     (TX_OUT),
      .Busy       (Busy)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; the request is sampled on the following posedge.
   task automatic send(input logic [7:0] d, input logic en, input logic typ, input logic [5:0] pre);
      P_DATA     = d;
      PAR_EN     = en;
      PAR_TYP    = typ;
      Prescale   = pre;
      Data_Valid = 1'b1;
      @(posedge CLK);
      #1;
      Data_Valid = 1'b0;
   endtask

   // bits[i] is frame bit i (start first); checks first and last cycle of each bit.
   task automatic check_frame(input string tag, input logic [10:0] bits, input int nbits, input int p);
      int f;
      int busy_cnt;
      int ph;
      f        = nbits * p;
      busy_cnt = 0;
      for (int c = 1; c <= f; c++) begin
         @(negedge CLK);
         if (Busy) busy_cnt++;
         ph = (c - 1) % p;
         if (ph == 0 || ph == p - 1)
            chk($sformatf("%s bit%0d cyc%0d", tag, (c - 1) / p, c), 32'(TX_OUT), 32'(bits[(c - 1) / p]));
      end
      @(negedge CLK);
      chk({tag, " idle_tx"},   32'(TX_OUT), 32'd1);
      chk({tag, " idle_busy"}, 32'(Busy),   32'd0);
      chk({tag, " busy_len"},  32'(busy_cnt), 32'(f));
   endtask

   task automatic watch_idle(input string tag, input int n);
      int busy_cnt;
      int low_cnt;
      busy_cnt = 0;
      low_cnt  = 0;
      for (int c = 0; c < n; c++) begin
         @(negedge CLK);
         if (Busy) busy_cnt++;
         if (!TX_OUT) low_cnt++;
      end
      chk({tag, " busy_cycles"}, 32'(busy_cnt), 32'd0);
      chk({tag, " low_cycles"},  32'(low_cnt),  32'd0);
   endtask

   // Mid-bit sampling receiver configured identically to the transmitter.
   task automatic rx_check(input logic [7:0] d, input logic en, input logic typ, input int p, input int idx);
      int         w;
      logic [7:0] rx;
      logic       pbit;
      logic       perr;
      logic       stop;
      w    = 0;
      rx   = 8'd0;
      pbit = 1'b0;
      @(negedge CLK);
      while (TX_OUT !== 1'b0 && w < 20) begin
         @(negedge CLK);
         w++;
      end
      chk($sformatf("lb%0d start_seen", idx), 32'(TX_OUT), 32'd0);
      repeat (p / 2) @(negedge CLK);
      chk($sformatf("lb%0d start_mid", idx), 32'(TX_OUT), 32'd0);
      for (int k = 0; k < 8; k++) begin
         repeat (p) @(negedge CLK);
         rx[k] = TX_OUT;
      end
      if (en) begin
         repeat (p) @(negedge CLK);
         pbit = TX_OUT;
      end
      perr = en & ((^rx) ^ typ ^ pbit);
      repeat (p) @(negedge CLK);
      stop = TX_OUT;
      chk($sformatf("lb%0d data", idx),   32'(rx),   32'(d));
      chk($sformatf("lb%0d par_err", idx), 32'(perr), 32'd0);
      chk($sformatf("lb%0d stop", idx),   32'(stop), 32'd1);
      w = 0;
      while (Busy && w < 200) begin
         @(negedge CLK);
         w++;
      end
      chk($sformatf("lb%0d idle", idx), 32'(Busy), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic [7:0] d;
      logic       en;
      logic       typ;
      logic [5:0] pre;
      int         p;

      RST        = 1'b1;
      P_DATA     = 8'h00;
      Data_Valid = 1'b0;
      PAR_EN     = 1'b0;
      PAR_TYP    = 1'b0;
      Prescale   = 6'd8;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("reset tx",   32'(TX_OUT), 32'd1);
      chk("reset busy", 32'(Busy),   32'd0);
      RST = 1'b0;
      @(negedge CLK);

      send(8'hA5, 1'b1, 1'b0, 6'd8);
      check_frame("a5_even", 11'b101_0100_1010, 11, 8);

      send(8'hA5, 1'b1, 1'b1, 6'd8);
      check_frame("a5_odd", 11'b111_0100_1010, 11, 8);

      send(8'h3C, 1'b0, 1'b0, 6'd16);
      check_frame("3c_nopar", 11'b010_0111_1000, 10, 16);

      send(8'h81, 1'b1, 1'b0, 6'd2);
      check_frame("clamp", 11'b101_0000_0010, 11, 4);

      // A request and new configuration mid-frame must not disturb the frame.
      send(8'hA5, 1'b1, 1'b0, 6'd8);
      fork
         check_frame("ignore", 11'b101_0100_1010, 11, 8);
         begin
            repeat (19) @(negedge CLK);
            P_DATA     = 8'hFF;
            PAR_EN     = 1'b0;
            PAR_TYP    = 1'b1;
            Prescale   = 6'd3;
            Data_Valid = 1'b1;
            @(negedge CLK);
            Data_Valid = 1'b0;
         end
      join
      watch_idle("ignore_after", 30);

      send(8'h3C, 1'b0, 1'b0, 6'd4);
      check_frame("b2b_first", 11'b010_0111_1000, 10, 4);
      send(8'hA5, 1'b1, 1'b1, 6'd4);
      check_frame("b2b_second", 11'b111_0100_1010, 11, 4);

      // Reset during data bit 3 (a zero bit of 0xA5).
      send(8'hA5, 1'b1, 1'b0, 6'd8);
      repeat (35) @(negedge CLK);
      chk("rst pre_tx",   32'(TX_OUT), 32'd0);
      chk("rst pre_busy", 32'(Busy),   32'd1);
      RST = 1'b1;
      @(negedge CLK);
      chk("rst tx",   32'(TX_OUT), 32'd1);
      chk("rst busy", 32'(Busy),   32'd0);
      RST = 1'b0;
      watch_idle("rst_after", 40);

      // Reset and request together: the request is dropped.
      P_DATA     = 8'h00;
      PAR_EN     = 1'b1;
      PAR_TYP    = 1'b0;
      Prescale   = 6'd4;
      RST        = 1'b1;
      Data_Valid = 1'b1;
      @(negedge CLK);
      RST        = 1'b0;
      Data_Valid = 1'b0;
      chk("rst_dv tx",   32'(TX_OUT), 32'd1);
      chk("rst_dv busy", 32'(Busy),   32'd0);
      watch_idle("rst_dv_after", 20);

      for (int i = 0; i < 256; i++) begin
         d   = 8'($urandom_range(255, 0));
         en  = 1'($urandom_range(1, 0));
         typ = 1'($urandom_range(1, 0));
         pre = 6'($urandom_range(8, 0));
         p   = (pre < 6'd4) ? 4 : int'(pre);
         send(d, en, typ, pre);
         rx_check(d, en, typ, p, i);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
